tube_sync: RTL

Fully synchronous, parametrised Tube ULA that replaces the latch-based design. It uses one clock domain, and both the host and parasite buses are presented as single-cycle read/write strobes. It provides four host-to-parasite (HP) and four parasite-to-host (PH) registers, the 7-bit control register and the interrupt/reset outputs. R3 is a configurable-depth FIFO with correct two-byte-mode hysteresis, and parasite reset is a timed pulse rather than a level.

---
 rtl/tube_sync.sv | 278 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/tube_sync.sv
// rtl/tube_sync.sv - Fully synchronous Tube ULA: HP/PH registers, R3 FIFOs, control, interrupts, parasite reset
module tube_r3_fifo #(
    parameter int         DEPTH     = 2,
    parameter logic [7:0] EMPTY_VAL = 8'h00,
    parameter logic       PRELOAD   = 1'b0
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       v_mode,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] rdata,
    output logic       dav,
    output logic       sav
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [7:0]    mem_d [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] cap;
    logic          dav_q, dav_d;
    logic          push_ok, pop_ok;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        cap      = v_mode ? DEPTH_C : CW'(1);
        push_ok  = push && (count_q < cap);
        pop_ok   = pop && (count_q != '0);
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (pop_ok) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + CW'(1);
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - CW'(1);
        end
        // Hysteresis: the flag only moves at full and at empty.
        dav_d = dav_q;
        if (count_d == '0) begin
            dav_d = 1'b0;
        end else if (count_d >= cap) begin
            dav_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= PRELOAD ? PW'(1) : '0;
            count_q  <= PRELOAD ? CW'(1) : '0;
            dav_q    <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            dav_q    <= dav_d;
        end
    end

    assign rdata = (count_q != '0) ? mem_q[rd_ptr_q] : EMPTY_VAL;
    assign dav   = v_mode ? dav_q : (count_q != '0);
    assign sav   = v_mode ? ~dav_q : (count_q == '0);
endmodule

module tube_sync #(
    parameter int         R3_DEPTH    = 2,
    parameter logic [7:0] HP3_EMPTY   = 8'hE4,
    parameter logic [7:0] PH3_EMPTY   = 8'h96,
    parameter int         PRST_CYCLES = 2560
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] h_addr,
    input  logic       h_wr,
    input  logic       h_rd,
    input  logic [7:0] h_wdata,
    output logic [7:0] h_rdata,
    output logic       h_irq,
    input  logic [2:0] p_addr,
    input  logic       p_wr,
    input  logic       p_rd,
    input  logic [7:0] p_wdata,
    output logic [7:0] p_rdata,
    output logic       p_irq,
    output logic       p_nmi,
    output logic       p_rst
);
    localparam int CTL_T = 6;
    localparam int CTL_P = 5;
    localparam int CTL_V = 4;
    localparam int CTL_M = 3;
    localparam int CTL_J = 2;
    localparam int CTL_I = 1;
    localparam int CTL_Q = 0;
    localparam int PCW   = $clog2(PRST_CYCLES + 1);
    localparam logic [PCW-1:0] PRST_C = PCW'(PRST_CYCLES);

    logic [6:0]     ctrl_q, ctrl_d;
    logic [PCW-1:0] prst_cnt_q, prst_cnt_d;
    logic           tube_rst;
    // Index 0/1/2 holds register 1/2/4 (addresses 1/3/7).
    logic [7:0]     hp_data_q [3];
    logic [7:0]     hp_data_d [3];
    logic [7:0]     ph_data_q [3];
    logic [7:0]     ph_data_d [3];
    logic [2:0]     hp_full_q, hp_full_d;
    logic [2:0]     ph_full_q, ph_full_d;
    logic           h_irq_q, h_irq_d;
    logic           p_irq_q, p_irq_d;
    logic           p_nmi_q, p_nmi_d;
    logic [7:0]     hp3_rdata, ph3_rdata;
    logic           hp3_dav, hp3_sav, ph3_dav, ph3_sav;

    function automatic logic [2:0] reg_addr(input int k);
        return (k == 2) ? 3'd7 : 3'(2 * k + 1);
    endfunction

    assign tube_rst = reset | ctrl_q[CTL_T];

    always_comb begin
        ctrl_d = ctrl_q;
        if (h_wr && h_addr == 3'd0) begin
            ctrl_d = h_wdata[7] ? (ctrl_q | h_wdata[6:0]) : (ctrl_q & ~h_wdata[6:0]);
        end
        // Counter is held loaded while P is set, so it restarts on every fall of P.
        if (ctrl_q[CTL_P]) begin
            prst_cnt_d = PRST_C;
        end else if (prst_cnt_q != '0) begin
            prst_cnt_d = prst_cnt_q - PCW'(1);
        end else begin
            prst_cnt_d = '0;
        end
    end

    always_comb begin
        hp_data_d = hp_data_q;
        ph_data_d = ph_data_q;
        hp_full_d = hp_full_q;
        ph_full_d = ph_full_q;
        for (int k = 0; k < 3; k++) begin
            // A same-cycle write wins over the opposite-side read clear.
            if (p_rd && p_addr == reg_addr(k)) hp_full_d[k] = 1'b0;
            if (h_wr && h_addr == reg_addr(k)) begin
                hp_data_d[k] = h_wdata;
                hp_full_d[k] = 1'b1;
            end
            if (h_rd && h_addr == reg_addr(k)) ph_full_d[k] = 1'b0;
            if (p_wr && p_addr == reg_addr(k)) begin
                ph_data_d[k] = p_wdata;
                ph_full_d[k] = 1'b1;
            end
        end
    end

    always_comb begin
        h_irq_d = ctrl_q[CTL_Q] & ph_full_q[2];
        p_irq_d = (ctrl_q[CTL_J] & hp_full_q[2]) | (ctrl_q[CTL_I] & hp_full_q[0]);
        p_nmi_d = ctrl_q[CTL_M] & (hp3_dav | ph3_sav);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q     <= 7'b0000001;
            prst_cnt_q <= PRST_C;
            h_irq_q    <= 1'b0;
            p_irq_q    <= 1'b0;
            p_nmi_q    <= 1'b0;
        end else begin
            ctrl_q     <= ctrl_d;
            prst_cnt_q <= prst_cnt_d;
            h_irq_q    <= h_irq_d;
            p_irq_q    <= p_irq_d;
            p_nmi_q    <= p_nmi_d;
        end
    end

    always_ff @(posedge clk) begin
        if (tube_rst) begin
            for (int k = 0; k < 3; k++) begin
                hp_data_q[k] <= 8'h00;
                ph_data_q[k] <= 8'h00;
            end
            hp_full_q <= '0;
            ph_full_q <= '0;
        end else begin
            hp_data_q <= hp_data_d;
            ph_data_q <= ph_data_d;
            hp_full_q <= hp_full_d;
            ph_full_q <= ph_full_d;
        end
    end

    tube_r3_fifo #(
        .DEPTH    (R3_DEPTH),
        .EMPTY_VAL(HP3_EMPTY),
        .PRELOAD  (1'b0)
    ) u_hp3 (
        .clk      (clk),
        .clr      (tube_rst),
        .v_mode   (ctrl_q[CTL_V]),
        .push     (h_wr && h_addr == 3'd5),
        .push_data(h_wdata),
        .pop      (p_rd && p_addr == 3'd5),
        .rdata    (hp3_rdata),
        .dav      (hp3_dav),
        .sav      (hp3_sav)
    );

    tube_r3_fifo #(
        .DEPTH    (R3_DEPTH),
        .EMPTY_VAL(PH3_EMPTY),
        .PRELOAD  (1'b1)
    ) u_ph3 (
        .clk      (clk),
        .clr      (tube_rst),
        .v_mode   (ctrl_q[CTL_V]),
        .push     (p_wr && p_addr == 3'd5),
        .push_data(p_wdata),
        .pop      (h_rd && h_addr == 3'd5),
        .rdata    (ph3_rdata),
        .dav      (ph3_dav),
        .sav      (ph3_sav)
    );

    always_comb begin
        h_rdata = 8'hFF;
        case (h_addr)
            3'd0:    h_rdata = {ph_full_q[0], ~hp_full_q[0], ctrl_q[5:0]};
            3'd1:    h_rdata = ph_data_q[0];
            3'd2:    h_rdata = {ph_full_q[1], ~hp_full_q[1], 6'h3F};
            3'd3:    h_rdata = ph_data_q[1];
            3'd4:    h_rdata = {ph3_dav, hp3_sav, 6'h3F};
            3'd5:    h_rdata = ph3_rdata;
            3'd6:    h_rdata = {ph_full_q[2], ~hp_full_q[2], 6'h3F};
            default: h_rdata = ph_data_q[2];
        endcase
    end

    always_comb begin
        p_rdata = 8'hFF;
        case (p_addr)
            3'd0:    p_rdata = {hp_full_q[0], ~ph_full_q[0], ctrl_q[5:0]};
            3'd1:    p_rdata = hp_data_q[0];
            3'd2:    p_rdata = {hp_full_q[1], ~ph_full_q[1], 6'h3F};
            3'd3:    p_rdata = hp_data_q[1];
            3'd4:    p_rdata = {hp3_dav | ph3_sav, ph3_sav, 6'h3F};
            3'd5:    p_rdata = hp3_rdata;
            3'd6:    p_rdata = {hp_full_q[2], ~ph_full_q[2], 6'h3F};
            default: p_rdata = hp_data_q[2];
        endcase
    end

    assign h_irq = h_irq_q;
    assign p_irq = p_irq_q;
    assign p_nmi = p_nmi_q;
    assign p_rst = reset | ctrl_q[CTL_P] | (prst_cnt_q != '0);
endmodule
